// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug dump host.
// State encoding, frame layout constants and byte selection helper.
package dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SETTLE,
        ST_SEND,
        ST_CSUM,
        ST_DONE,
        ST_STEP_H,
        ST_STEP_L
    } dbg_state_e;

    localparam int         DBG_BYTES_PER_ENTRY = 5;
    localparam logic [7:0] DBG_HEADER_DEFAULT  = 8'hA5;

    // Byte idx of an entry: 1..4 are the data word, MSB first.
    function automatic logic [7:0] dbg_byte_sel(
        input logic [31:0] word,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_step_pulse.sv
// Single debug step pulse generator.
// A trigger yields STEP_HI cycles high then STEP_HI cycles low.
module dbg_step_pulse #(
    parameter int STEP_HI = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic step_o,
    output logic idle_o,
    output logic phase_done_o
);

    localparam int CW = (STEP_HI > 1) ? $clog2(STEP_HI) : 1;

    logic          active_q, active_d;
    logic          low_q, low_d;
    logic          step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_done_o = active_q && (cnt_q == CW'(STEP_HI - 1));
    assign step_o       = step_q;
    assign idle_o       = !active_q;

    // High phase, then low phase, each counted to STEP_HI.
    always_comb begin
        active_d = active_q;
        low_d    = low_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        if (!active_q) begin
            if (trig_i) begin
                active_d = 1'b1;
                low_d    = 1'b0;
                step_d   = 1'b1;
                cnt_d    = '0;
            end
        end else if (phase_done_o) begin
            cnt_d = '0;
            if (!low_q) begin
                low_d  = 1'b1;
                step_d = 1'b0;
            end else begin
                low_d    = 1'b0;
                active_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulse state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            low_q    <= 1'b0;
            step_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            low_q    <= low_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_dump_host.sv
// Debug port host: sweeps all debug addresses into a framed byte
// stream and issues single debug step pulses on request.
module dbg_dump_host
    import dbg_pkg::*;
#(
    parameter int         NUM_ADDR = 64,
    parameter int         SETTLE   = 2,
    parameter int         STEP_HI  = 4,
    parameter logic [7:0] HEADER   = DBG_HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_req,
    output logic        busy,
    output logic        done,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        debug_step,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    dbg_state_e    state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [31:0]   cap_q, cap_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    txd_q, txd_d;
    logic          txv_q, txv_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          trig;
    logic          p_idle;
    logic          p_done;
    logic          accept;
    logic [7:0]    csum_n;

    assign accept = txv_q && tx_ready;
    assign csum_n = csum_q ^ txd_q;

    dbg_step_pulse #(
        .STEP_HI(STEP_HI)
    ) u_step (
        .clk         (clk),
        .rst         (rst),
        .trig_i      (trig),
        .step_o      (debug_step),
        .idle_o      (p_idle),
        .phase_done_o(p_done)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        csum_d  = csum_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        done_d  = 1'b0;
        trig    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                    txv_d   = 1'b1;
                    txd_d   = HEADER;
                end else if (step_req && p_idle) begin
                    state_d = ST_STEP_H;
                    trig    = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                    addr_d  = '0;
                    csum_d  = '0;
                    scnt_d  = '0;
                    txv_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SW'(SETTLE - 1)) begin
                    state_d = ST_SEND;
                    cap_d   = debug_data;
                    idx_d   = '0;
                    txv_d   = 1'b1;
                    txd_d   = {1'b0, addr_q};
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    csum_d = csum_n;
                    if (idx_q == 3'(DBG_BYTES_PER_ENTRY - 1)) begin
                        if (addr_q == 7'(NUM_ADDR - 1)) begin
                            state_d = ST_CSUM;
                            txd_d   = csum_n;
                        end else begin
                            state_d = ST_SETTLE;
                            addr_d  = addr_q + 1'b1;
                            scnt_d  = '0;
                            txv_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        txd_d = dbg_byte_sel(cap_q, idx_q + 1'b1);
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = ST_DONE;
                    txv_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            ST_STEP_H: begin
                if (p_done) state_d = ST_STEP_L;
            end
            ST_STEP_L: begin
                if (p_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cap_q   <= '0;
            idx_q   <= '0;
            scnt_q  <= '0;
            csum_q  <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            csum_q  <= csum_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign debug_addr = addr_q;
    assign tx_data    = txd_q;
    assign tx_valid   = txv_q;

endmodule

// File: tb/tb_dbg_dump_host.sv
// Directed bench for dbg_dump_host.
// Frames are checked against a byte model built by the bench.
module tb_dbg_dump_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_req = 1'b0;
    logic        busy;
    logic        done;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic        debug_step;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errs = 0;
    int checks = 0;
    int mode = 0;
    bit bp_en = 1'b0;
    logic [31:0] dd_q = '0;
    logic [7:0] rxq[$];
    int done_cnt = 0;
    int step_cnt = 0;
    int stab_err = 0;
    bit pv = 1'b0;
    logic [7:0] pd = '0;

    always #5 clk = ~clk;

    dbg_dump_host dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_req  (step_req),
        .busy      (busy),
        .done      (done),
        .debug_addr(debug_addr),
        .debug_data(debug_data),
        .debug_step(debug_step),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    function automatic logic [31:0] dmodel(input int m,
                                           input logic [6:0] a);
        if (m == 1) return 32'hC0DE0000 | {25'b0, a};
        return {25'b0, a};
    endfunction

    always @(posedge clk) dd_q <= dmodel(0, debug_addr);

    assign debug_data = (mode == 2) ? dd_q : dmodel(mode, debug_addr);

    always @(negedge clk)
        tx_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;

    always @(posedge clk) begin
        if (!rst) begin
            pv = 1'b0;
        end else begin
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            if (done) done_cnt++;
            if (debug_step) step_cnt++;
            if (pv && (!tx_valid || tx_data !== pd)) stab_err++;
            pv = tx_valid && !tx_ready;
            pd = tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < lim) begin
            @(posedge clk);
            #1 n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cmp_frame(input string tag, input int m);
        logic [7:0] exp[$];
        logic [7:0] cs;
        logic [31:0] w;
        int bad;
        exp.push_back(8'hA5);
        cs = 8'h00;
        for (int a = 0; a < 64; a++) begin
            w = dmodel(m, 7'(a));
            exp.push_back(8'(a));
            exp.push_back(w[31:24]);
            exp.push_back(w[23:16]);
            exp.push_back(w[15:8]);
            exp.push_back(w[7:0]);
            cs = cs ^ 8'(a) ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        exp.push_back(cs);
        chk({tag, "_len"}, rxq.size(), 322);
        bad = 0;
        for (int i = 0; i < exp.size(); i++) begin
            if (i >= rxq.size() || rxq[i] !== exp[i]) bad++;
        end
        chk({tag, "_bytes_bad"}, bad, 0);
    endtask

    initial begin
        int n;
        bit ok;
        int hi;
        int bz;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", debug_addr, 0);
        chk("rst_step", debug_step, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        // full dump, tx_ready held high
        mode = 0;
        rxq.delete();
        done_cnt = 0;
        start_dump();
        chk("hdr_busy", busy, 1);
        chk("hdr_valid", tx_valid, 1);
        chk("hdr_data", tx_data, 8'hA5);
        wait_done(2000, n, ok);
        chk("full_done_seen", ok, 1);
        chk("full_latency", n, 450);
        @(posedge clk);
        #1;
        chk("full_done_one", done, 0);
        chk("full_idle", busy, 0);
        chk("full_addr0", debug_addr, 0);
        chk("full_done_cnt", done_cnt, 1);
        cmp_frame("full", 0);
        chk("full_csum", rxq[rxq.size()-1], 8'h00);

        // backpressure at about 30% ready
        mode = 1;
        bp_en = 1'b1;
        rxq.delete();
        done_cnt = 0;
        stab_err = 0;
        start_dump();
        wait_done(20000, n, ok);
        chk("bp_done_seen", ok, 1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_stable", stab_err, 0);
        cmp_frame("bp", 1);

        // data lags address by one cycle
        mode = 2;
        rxq.delete();
        start_dump();
        wait_done(2000, n, ok);
        chk("settle_done_seen", ok, 1);
        repeat (2) @(posedge clk);
        cmp_frame("settle", 0);
        mode = 0;

        // single step, extra request during the pulse
        step_cnt = 0;
        @(negedge clk) step_req = 1'b1;
        @(posedge clk);
        #1 step_req = 1'b0;
        chk("step_first", debug_step, 1);
        chk("step_busy", busy, 1);
        hi = 1;
        bz = 1;
        @(negedge clk) step_req = 1'b1;
        @(posedge clk);
        #1 step_req = 1'b0;
        hi += int'(debug_step);
        bz += int'(busy);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            hi += int'(debug_step);
            bz += int'(busy);
        end
        chk("step_hi_cycles", hi, 4);
        chk("step_busy_cycles", bz, 8);
        chk("step_total", step_cnt, 4);

        // start and step_req together
        step_cnt = 0;
        rxq.delete();
        @(negedge clk);
        start = 1'b1;
        step_req = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        step_req = 1'b0;
        wait_done(2000, n, ok);
        chk("coll_done_seen", ok, 1);
        repeat (12) @(posedge clk);
        chk("coll_no_step", step_cnt, 0);
        cmp_frame("coll", 0);

        // reset while sending address 10
        rxq.delete();
        start_dump();
        n = 0;
        while (n < 2000 && !(tx_valid && debug_addr == 7'd10)) begin
            @(posedge clk);
            #1 n++;
        end
        chk("mid_reach_a10", n < 2000, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", tx_valid, 0);
        chk("mid_data", tx_data, 0);
        chk("mid_addr", debug_addr, 0);
        chk("mid_done", done, 0);
        chk("mid_step", debug_step, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        rxq.delete();
        start_dump();
        chk("mid_hdr", tx_data, 8'hA5);
        wait_done(2000, n, ok);
        chk("mid_done_seen", ok, 1);
        repeat (2) @(posedge clk);
        cmp_frame("mid", 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
